// File: rtl/uart_tx_ctrl_if.sv
// Byte-in / mux-control-out bundle of the UART transmit controller.
// master: the byte producer, which also watches the mux controls.
// slave:  the controller, which drives the mux controls.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            MUX_SEL;
    logic                  SER_DATA;
    logic                  PAR_BIT;
    logic                  BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  MUX_SEL, SER_DATA, PAR_BIT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output MUX_SEL, SER_DATA, PAR_BIT, BUSY
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer. It emits one frame bit per CLK cycle:
// start, then DATA_WIDTH data bits LSB first, then an optional parity bit,
// then stop. It drives the select, data and parity inputs of the TX mux.
//
// state  | meaning
// IDLE   | line at stop level; accept a word when DATA_VALID is high
// START  | start bit, one cycle
// DATA   | DATA_WIDTH cycles, shift register LSB on SER_DATA
// PARITY | parity bit, one cycle, only when latched PAR_EN is set
// STOP   | stop bit, one cycle, then back to IDLE
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic [1:0]            mux_sel_q;
    logic                  busy_q;
    logic                  par_bit_q;

    // Frame sequencer. MUX_SEL and BUSY are registered next to the state so
    // they always equal the decode of the state being entered; no input
    // reaches an output without passing through a flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            mux_sel_q <= SEL_STOP;
            busy_q    <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.DATA_VALID) begin
                        shift_reg <= bus.P_DATA;
                        par_en_q  <= bus.PAR_EN;
                        // Parity is computed once at acceptance and held
                        // until the next word, so later input changes cannot
                        // disturb the frame in flight.
                        par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        state     <= START;
                        mux_sel_q <= SEL_START;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    bit_cnt   <= '0;
                    state     <= DATA;
                    mux_sel_q <= SEL_DATA;
                end
                DATA: begin
                    shift_reg <= shift_reg >> 1;
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            state     <= PARITY;
                            mux_sel_q <= SEL_PARITY;
                        end else begin
                            state     <= STOP;
                            mux_sel_q <= SEL_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    state     <= STOP;
                    mux_sel_q <= SEL_STOP;
                end
                STOP: begin
                    state     <= IDLE;
                    mux_sel_q <= SEL_STOP;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mux_sel_q <= SEL_STOP;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Outside DATA the serial bit is simply the register LSB, which keeps it
    // deterministic even though the mux ignores it there.
    assign bus.SER_DATA = shift_reg[0];
    assign bus.MUX_SEL  = mux_sel_q;
    assign bus.BUSY     = busy_q;
    assign bus.PAR_BIT  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: an 8-bit and a 5-bit instance share CLK, RST and
// the data/parity inputs, each with its own DATA_VALID. Expected frames are
// built from the frame rules (bit positions, ones count) per word.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [8:0] pd  = '0;
    logic       dv8 = 1'b0;
    logic       dv5 = 1'b0;
    logic       pen = 1'b0;
    logic       ptyp = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) b8 ();
    uart_tx_ctrl_if #(.DATA_WIDTH(5)) b5 ();

    assign b8.P_DATA     = pd[7:0];
    assign b8.DATA_VALID = dv8;
    assign b8.PAR_EN     = pen;
    assign b8.PAR_TYP    = ptyp;
    assign b5.P_DATA     = pd[4:0];
    assign b5.DATA_VALID = dv5;
    assign b5.PAR_EN     = pen;
    assign b5.PAR_TYP    = ptyp;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(b8));
    uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (.CLK(CLK), .RST(RST), .bus(b5));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input bit sel, output logic [1:0] mux, output logic ser,
                          output logic par, output logic busy);
        if (sel) begin
            mux = b5.MUX_SEL; ser = b5.SER_DATA; par = b5.PAR_BIT; busy = b5.BUSY;
        end else begin
            mux = b8.MUX_SEL; ser = b8.SER_DATA; par = b8.PAR_BIT; busy = b8.BUSY;
        end
    endtask

    // Called right after the acceptance edge; walks the whole frame and the
    // first idle cycle after it.
    task automatic check_frame(input bit sel, input int word, input bit p_en,
                               input bit p_typ, input string name);
        int w;
        int len;
        int ones;
        logic [1:0] e_mux;
        logic e_par;
        logic [1:0] o_mux;
        logic o_ser, o_par, o_busy;
        w = sel ? 5 : 8;
        len = 2 + w + (p_en ? 1 : 0);
        ones = 0;
        for (int i = 0; i < w; i++) ones += (word >> i) & 1;
        e_par = 1'((ones % 2) ^ (p_typ ? 1 : 0));
        for (int k = 0; k < len; k++) begin
            if (k == 0) e_mux = 2'b00;
            else if (k <= w) e_mux = 2'b01;
            else if (k == w + 1 && p_en) e_mux = 2'b10;
            else e_mux = 2'b11;
            sample(sel, o_mux, o_ser, o_par, o_busy);
            checks++;
            if (o_mux !== e_mux) begin
                errors++;
                $display("FAIL %s mux cyc%0d got %0d want %0d", name, k, o_mux, e_mux);
            end
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc%0d got %0b want 1", name, k, o_busy);
            end
            checks++;
            if (o_par !== e_par) begin
                errors++;
                $display("FAIL %s par_bit cyc%0d got %0b want %0b", name, k, o_par, e_par);
            end
            if (k >= 1 && k <= w) begin
                checks++;
                if (o_ser !== 1'((word >> (k - 1)) & 1)) begin
                    errors++;
                    $display("FAIL %s ser bit%0d got %0b want %0d", name, k - 1, o_ser,
                             (word >> (k - 1)) & 1);
                end
            end
            tick();
        end
        sample(sel, o_mux, o_ser, o_par, o_busy);
        checks++;
        if (o_mux !== 2'b11 || o_busy !== 1'b0 || o_par !== e_par) begin
            errors++;
            $display("FAIL %s idle_after got mux=%0d busy=%0b par=%0b want mux=3 busy=0 par=%0b",
                     name, o_mux, o_busy, o_par, e_par);
        end
    endtask

    // Present a word for one edge; optionally scramble inputs after acceptance.
    task automatic send(input bit sel, input int word, input bit p_en, input bit p_typ,
                        input bit scramble, input string name);
        pd = 9'(word); pen = p_en; ptyp = p_typ;
        if (sel) dv5 = 1'b1; else dv8 = 1'b1;
        tick();
        dv5 = 1'b0; dv8 = 1'b0;
        if (scramble) begin
            pd = 9'($urandom_range(511, 0));
            pen = 1'($urandom_range(1, 0));
            ptyp = 1'($urandom_range(1, 0));
        end
        check_frame(sel, word, p_en, p_typ, name);
    endtask

    task automatic test_reset();
        logic [1:0] o_mux;
        logic o_ser, o_par, o_busy;
        RST = 1'b1; dv8 = 1'b1; pd = 9'h0A5; pen = 1'b1; ptyp = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            sample(1'b0, o_mux, o_ser, o_par, o_busy);
            checks++;
            if (o_mux !== 2'b11 || o_busy !== 1'b0 || o_par !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d got mux=%0d busy=%0b par=%0b want 3 0 0",
                         c, o_mux, o_busy, o_par);
            end
        end
        RST = 1'b0;
        tick();
        dv8 = 1'b0;
        check_frame(1'b0, 32'h0A5, 1'b1, 1'b1, "reset_release");
    endtask

    task automatic test_even_odd_nopar();
        send(1'b0, 32'hA5, 1'b1, 1'b0, 1'b1, "even_a5");
        tick();
        send(1'b0, 32'hA5, 1'b1, 1'b1, 1'b1, "odd_a5");
        tick();
        send(1'b0, 32'h80, 1'b0, 1'b0, 1'b1, "nopar_80");
    endtask

    task automatic test_ignore_busy();
        pd = 9'h0FF; pen = 1'b1; ptyp = 1'b0; dv8 = 1'b1;
        tick();
        pd = 9'h03C;
        check_frame(1'b0, 32'hFF, 1'b1, 1'b0, "busy_ff");
        tick();
        dv8 = 1'b0;
        check_frame(1'b0, 32'h3C, 1'b1, 1'b0, "queued_3c");
    endtask

    task automatic test_midframe_reset();
        logic [1:0] o_mux;
        logic o_ser, o_par, o_busy;
        pd = 9'h055; pen = 1'b1; ptyp = 1'b1; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        sample(1'b0, o_mux, o_ser, o_par, o_busy);
        checks++;
        if (o_mux !== 2'b11 || o_busy !== 1'b0 || o_par !== 1'b0) begin
            errors++;
            $display("FAIL midreset got mux=%0d busy=%0b par=%0b want 3 0 0",
                     o_mux, o_busy, o_par);
        end
        RST = 1'b0;
        tick();
        send(1'b0, 32'h0F, 1'b1, 1'b0, 1'b0, "after_reset_0f");
    endtask

    task automatic test_width5();
        send(1'b1, 32'h1B, 1'b1, 1'b0, 1'b1, "w5_1b");
        tick();
        send(1'b1, 32'h12, 1'b0, 1'b1, 1'b1, "w5_12_nopar");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int sel;
            int word;
            sel = $urandom_range(1, 0);
            word = sel ? $urandom_range(31, 0) : $urandom_range(255, 0);
            send(1'(sel), word, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 1'b1, "random");
            repeat ($urandom_range(3, 1)) tick();
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_even_odd_nopar();
        tick();
        test_ignore_busy();
        tick();
        test_midframe_reset();
        tick();
        test_width5();
        tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
